// File: rtl/memory_arbiter.sv
// memory_arbiter: shares a single-ported memory between a fetch port and a data port
// with a fixed IDLE -> ACCESS -> RESPOND sequence per transaction.
module memory_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_request,
    input  logic [15:0] fetch_address,
    output logic        fetch_ready,
    output logic [15:0] fetch_data,
    input  logic        data_request,
    input  logic        data_write,
    input  logic        data_select_byte,
    input  logic [15:0] data_address,
    input  logic [15:0] data_input,
    output logic        data_ready,
    output logic [15:0] data_output,
    output logic        busy,
    output logic        memory_write,
    output logic        memory_select_byte,
    output logic [15:0] memory_address,
    output logic [15:0] memory_input_data,
    input  logic [15:0] memory_output_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
    state_t      state;
    logic        owner;
    logic        last_grant;
    logic        cmd_write;
    logic        cmd_byte;
    logic [15:0] cmd_address;
    logic [15:0] cmd_input;
    logic        grant_data;
    logic [15:0] result;
    // owner/last_grant: 1 = data port, 0 = fetch port
    always_comb begin
        grant_data = data_request & (~fetch_request | ~ROUND_ROBIN | ~last_grant);
        result     = cmd_byte ? {8'h00, cmd_address[0] ? memory_output_data[15:8] : memory_output_data[7:0]}
                              : memory_output_data;
    end
    assign busy               = state != IDLE;
    assign memory_write       = (state == ACCESS) & cmd_write & ~reset;
    assign memory_select_byte = (state == ACCESS) & cmd_byte;
    assign memory_address     = cmd_address;
    assign memory_input_data  = cmd_input;
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            cmd_write   <= 1'b0;
            cmd_byte    <= 1'b0;
            cmd_address <= 16'h0000;
            cmd_input   <= 16'h0000;
            fetch_ready <= 1'b0;
            data_ready  <= 1'b0;
            fetch_data  <= 16'h0000;
            data_output <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_request | data_request) begin
                        owner       <= grant_data;
                        last_grant  <= grant_data;
                        cmd_address <= grant_data ? data_address : fetch_address;
                        cmd_write   <= grant_data & data_write;
                        cmd_byte    <= grant_data & data_select_byte;
                        if (grant_data)
                            cmd_input <= data_input;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (owner) begin
                        data_ready <= 1'b1;
                        if (!cmd_write)
                            data_output <= result;
                    end else begin
                        fetch_ready <= 1'b1;
                        fetch_data  <= result;
                    end
                    state <= RESPOND;
                end
                default: begin
                    fetch_ready <= 1'b0;
                    data_ready  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported memory_unit. It shares that memory between a read-only instruction fetch port and a read/write data port. Each port uses a request/ready handshake. The block registers the winning command, drives the memory for exactly one access cycle, captures the combinational read data, and returns it with a one-cycle ready pulse. It sits between the core's fetch/load-store logic and memory_unit.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grants on contention; 0 = data port always wins contention.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
fetch_request  input  1  fetch port requests a word read; held until fetch_ready.
fetch_address  input  16  fetch byte address; bit 0 is ignored by memory.
fetch_ready  output  1  one-cycle pulse: fetch_data valid.
fetch_data  output  16  fetched word, registered.
data_request  input  1  data port requests an access; held until data_ready.
data_write  input  1  1 = write, 0 = read.
data_select_byte  input  1  1 = byte access at data_address[0], 0 = word access.
data_address  input  16  data byte address.
data_input  input  16  write data; a byte write uses bits [7:0].
data_ready  output  1  one-cycle pulse: access complete and data_output valid.
data_output  output  16  read result, registered; byte reads are zero-extended.
busy  output  1  high in any state other than IDLE.
memory_write  output  1  to memory_unit.write.
memory_select_byte  output  1  to memory_unit.select_byte.
memory_address  output  16  to memory_unit.address.
memory_input_data  output  16  to memory_unit.input_data.
memory_output_data  input  16  from memory_unit.output_data (combinational read).

Behaviour:
- Reset state: IDLE. fetch_ready=0, data_ready=0, fetch_data=0, data_output=0, busy=0, memory_write=0. Latched command = 0. last_grant = DATA, so fetch wins the first tie.
- States: IDLE -> ACCESS -> RESPOND -> IDLE. Fixed latency: request sampled at edge N, ready high during cycle N+2. Maximum throughput is one transaction per 3 cycles.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that port. Latch owner, address, write, select_byte and input data (fetch: write=0, select_byte=0). Go to ACCESS.
- IDLE, both requests:
  - ROUND_ROBIN=1: grant the port that is not last_grant.
  - ROUND_ROBIN=0: grant the data port.
  - Update last_grant to the granted port in both modes.
- ACCESS, memory drive:
  - memory_address, memory_select_byte and memory_input_data come from the latched command.
  - memory_write = latched write AND NOT reset, so a reset sampled in this cycle suppresses the write.
  - On the edge, capture the read result into the owner's output register. Non-owner output registers hold their value.
- ACCESS, read formatting:
  - Word read: result = memory_output_data.
  - Byte read: result = {8'h00, address[0] ? memory_output_data[15:8] : memory_output_data[7:0]}.
  - Writes: data_output holds its previous value.
  - Then go to RESPOND.
- RESPOND: the owner's ready = 1 for this cycle only. Requests sampled in this cycle are ignored. Go to IDLE. A requester whose request is still high in IDLE is treated as a new request.
- Outside ACCESS: memory_write=0, memory_select_byte=0, memory_address and memory_input_data hold the latched values.
- Ready signals are never both high. Ready is never high outside RESPOND.
- Requests are not queued. A port not granted stays pending while its request is held, and is granted in the next IDLE.
- Reset mid-transaction (any state): next state IDLE, ready outputs 0, no write performed. last_grant resets to DATA.
- Input changes on a port after its grant do not affect the transaction in flight.

Test Plan:
- After reset, fetch_request=1 with fetch_address=0x0002 at edge 0 -> fetch_ready=1 in cycle 2, fetch_data=0x0180; busy high in cycles 1–2.
- Data byte read, address=0x0001, select_byte=1 -> data_output=0x00FE. Byte read at 0x0000 -> 0x0001. Word read at 0x0006 -> 0x0181.
- Both requests held from reset, ROUND_ROBIN=1 -> fetch served first (ready in cycle 2), then data (ready in cycle 5), then fetch again. With ROUND_ROBIN=0, data is served first.
- Data word write 0xBEEF at 0x0004 -> memory_write high in exactly one cycle. A following fetch of 0x0004 -> fetch_data=0xBEEF.
- Byte write data_input=0x0012 at 0x0007 with select_byte=1 -> a word read at 0x0006 returns 0x1281.
- Write of 0xAAAA at 0x0004 with reset asserted during its ACCESS cycle -> memory_write stays 0, data_ready never pulses, and a later word read at 0x0004 returns 0x0101.
